clock_divider_controller: RTL and testbench

Sequencer that owns the 24-bit divisor input of the ClockDivider and changes it safely at runtime. Takes divisor change requests over a valid/ready handshake, applies each change only just after a rising edge of the divided clock, optionally ramping toward the target in fixed steps, and reports completion. It sits between configuration logic and the divider. No other block drives `clock_divider`.

---
 rtl/clock_divider_controller.sv | 178 +++++++++++++++++
 tb/tb_clock_divider_controller.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_divider_controller.sv
// -----------------------------------------------------------------------------
// clock_divider_controller
//
// Owns the divisor input of the ClockDivider and changes it safely while the
// divider is running. A change request (target, step, dwell) is accepted over
// a valid/ready handshake. Each divisor update is applied only just after a
// rising edge of the divided clock. Updates can optionally ramp toward the
// target in fixed-size steps.
//
// Ports
//   clock            system clock; also clocks the divider
//   reset            asynchronous, active-high reset
//   request_valid    change request present
//   request_ready    controller can accept a request (high only when idle)
//   request_divider  target divisor
//   request_step     ramp step size; 0 jumps directly to the target
//   request_dwell    divided-clock rising edges to wait before each step
//                    (0 behaves as 1)
//   output_clock     divided clock fed back from the divider
//   clock_divider    registered divisor driven to the divider
//   busy             a request is in progress
//   done             one-cycle pulse once the target has been reached
//   timed_out        sticky per request: some wait gave up on output_clock
// -----------------------------------------------------------------------------
module clock_divider_controller #(
    parameter int                WIDTH          = 24,
    parameter logic [WIDTH-1:0]  RESET_DIVIDER  = {{(WIDTH-1){1'b0}}, 1'b1},
    parameter int                TIMEOUT_CYCLES = 1024
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             request_valid,
    output logic             request_ready,
    input  logic [WIDTH-1:0] request_divider,
    input  logic [WIDTH-1:0] request_step,
    input  logic [7:0]       request_dwell,
    input  logic             output_clock,
    output logic [WIDTH-1:0] clock_divider,
    output logic             busy,
    output logic             done,
    output logic             timed_out
);

    localparam int             CW           = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0]  TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_APPLY,
        S_DONE
    } state_t;

    state_t           state_reg,     state_next;
    logic [WIDTH-1:0] divider_reg,   divider_next;
    logic [WIDTH-1:0] target_reg,    target_next;
    logic [WIDTH-1:0] step_reg,      step_next;
    logic [7:0]       dwell_reg,     dwell_next;
    logic [7:0]       edge_cnt_reg,  edge_cnt_next;
    logic [CW-1:0]    cycle_cnt_reg, cycle_cnt_next;
    logic             timed_out_reg, timed_out_next;
    logic             out_q;

    logic             edge_pulse;
    logic [7:0]       dwell_eff;
    logic             dwell_hit;
    logic             timeout_hit;
    logic             ramp_up;
    logic [WIDTH-1:0] distance;
    logic [WIDTH-1:0] step_value;

    // out_q resets high so output_clock already high at reset release is
    // not mistaken for a rising edge.
    assign edge_pulse  = output_clock & ~out_q;
    assign dwell_eff   = (dwell_reg == 8'd0) ? 8'd1 : dwell_reg;
    // The edge counter stays below dwell_eff, so the +1 cannot overflow.
    assign dwell_hit   = edge_pulse && ((edge_cnt_reg + 8'd1) == dwell_eff);
    assign timeout_hit = (cycle_cnt_reg == TIMEOUT_LAST);

    // Next divisor value. The distance is taken larger-minus-smaller so it
    // never wraps, and a step is clamped to the target when the remaining
    // distance is within one step, so a ramp never overshoots.
    always_comb begin
        ramp_up  = (target_reg > divider_reg);
        distance = ramp_up ? (target_reg - divider_reg) : (divider_reg - target_reg);
        if ((step_reg == '0) || (distance <= step_reg)) begin
            step_value = target_reg;
        end else if (ramp_up) begin
            step_value = divider_reg + step_reg;
        end else begin
            step_value = divider_reg - step_reg;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            divider_reg   <= RESET_DIVIDER;
            target_reg    <= RESET_DIVIDER;
            step_reg      <= '0;
            dwell_reg     <= '0;
            edge_cnt_reg  <= '0;
            cycle_cnt_reg <= '0;
            timed_out_reg <= 1'b0;
            out_q         <= 1'b1;
        end else begin
            state_reg     <= state_next;
            divider_reg   <= divider_next;
            target_reg    <= target_next;
            step_reg      <= step_next;
            dwell_reg     <= dwell_next;
            edge_cnt_reg  <= edge_cnt_next;
            cycle_cnt_reg <= cycle_cnt_next;
            timed_out_reg <= timed_out_next;
            out_q         <= output_clock;
        end
    end

    always_comb begin
        state_next     = state_reg;
        divider_next   = divider_reg;
        target_next    = target_reg;
        step_next      = step_reg;
        dwell_next     = dwell_reg;
        edge_cnt_next  = edge_cnt_reg;
        cycle_cnt_next = cycle_cnt_reg;
        timed_out_next = timed_out_reg;

        case (state_reg)
            S_IDLE: begin
                if (request_valid) begin
                    target_next    = request_divider;
                    step_next      = request_step;
                    dwell_next     = request_dwell;
                    timed_out_next = 1'b0;
                    edge_cnt_next  = '0;
                    cycle_cnt_next = '0;
                    state_next     = (request_divider == divider_reg) ? S_DONE : S_WAIT;
                end
            end

            S_WAIT: begin
                if (dwell_hit || timeout_hit) begin
                    state_next = S_APPLY;
                    // An edge landing on the timeout cycle counts as an edge.
                    if (timeout_hit && !edge_pulse) begin
                        timed_out_next = 1'b1;
                    end
                end else begin
                    edge_cnt_next  = edge_cnt_reg + {7'd0, edge_pulse};
                    cycle_cnt_next = cycle_cnt_reg + 1'b1;
                end
            end

            S_APPLY: begin
                divider_next   = step_value;
                edge_cnt_next  = '0;
                cycle_cnt_next = '0;
                state_next     = (step_value == target_reg) ? S_DONE : S_WAIT;
            end

            S_DONE: begin
                state_next = S_IDLE;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign clock_divider = divider_reg;
    assign request_ready = (state_reg == S_IDLE);
    assign busy          = (state_reg != S_IDLE);
    assign done          = (state_reg == S_DONE);
    assign timed_out     = timed_out_reg;

endmodule

// File: tb/tb_clock_divider_controller.sv
// -----------------------------------------------------------------------------
// tb_clock_divider_controller
//
// Self-checking bench for clock_divider_controller. Each request is run
// against a precomputed output_clock waveform; a reference model derives the
// expected divisor, done, ready/busy and timed_out per cycle from the
// waveform with plain arithmetic. A table of directed requests, a few
// hand-written sequences (reset, handshake, reset mid-ramp) and randomized
// requests drive the DUT.
// -----------------------------------------------------------------------------
module tb_clock_divider_controller;

    localparam int W    = 24;
    localparam int TO   = 1024;
    localparam int MAXC = 4096;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic           request_valid = 1'b0;
    logic           request_ready;
    logic [W-1:0]   request_divider = '0;
    logic [W-1:0]   request_step = '0;
    logic [7:0]     request_dwell = '0;
    logic           output_clock = 1'b0;
    logic [W-1:0]   clock_divider;
    logic           busy;
    logic           done;
    logic           timed_out;

    clock_divider_controller #(
        .WIDTH          (W),
        .RESET_DIVIDER  (24'd1),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .request_valid   (request_valid),
        .request_ready   (request_ready),
        .request_divider (request_divider),
        .request_step    (request_step),
        .request_dwell   (request_dwell),
        .output_clock    (output_clock),
        .clock_divider   (clock_divider),
        .busy            (busy),
        .done            (done),
        .timed_out       (timed_out)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] model_div;
    bit           oc_wave  [MAXC];
    logic [W-1:0] exp_div  [MAXC];
    int           exp_done_cyc;
    bit           exp_to;
    bit           model_ok;
    logic [W-1:0] obs_div  [MAXC];
    logic         obs_done [MAXC];
    logic         obs_rdy  [MAXC];
    logic         obs_busy [MAXC];
    logic         obs_to   [MAXC];

    typedef struct {
        logic [W-1:0] tgt;
        logic [W-1:0] stp;
        logic [7:0]   dw;
        int           first;
        int           half;
        int           me;
        int           nsteps;
        bit           to;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // output_clock low until cycle 'first', then a square wave of period
    // 2*half starting high; after 'me' rising edges (me >= 0) it stays low.
    function automatic void build_wave(input int first, input int half, input int me);
        for (int k = 0; k < MAXC; k++) begin
            if (k < first) begin
                oc_wave[k] = 1'b0;
            end else begin
                oc_wave[k] = (((k - first) % (2 * half)) < half);
                if (me >= 0 && ((k - first) / (2 * half)) >= me) oc_wave[k] = 1'b0;
            end
        end
    endfunction

    // Expected behaviour of one request accepted in cycle 0 from divisor cur.
    function automatic void predict(input logic [W-1:0] cur, input logic [W-1:0] tgt,
                                    input logic [W-1:0] stp, input logic [7:0] dw);
        longint c, t, s, diff, nxt;
        int     w, m, cnt, dwe;
        bit     e, to_hit;
        c = cur; t = tgt; s = stp;
        exp_to = 1'b0;
        model_ok = 1'b1;
        for (int k = 0; k < MAXC; k++) exp_div[k] = cur;
        if (c == t) begin
            exp_done_cyc = 1;
            return;
        end
        dwe = (dw == 8'd0) ? 1 : int'(dw);
        w = 1;
        while (1) begin
            cnt = 0; m = -1; to_hit = 1'b0;
            for (int k = w; k < w + TO && k < MAXC; k++) begin
                e = oc_wave[k] && !oc_wave[k-1];
                if (e) cnt++;
                if (cnt == dwe) begin
                    m = k;
                    break;
                end
                if (k == w + TO - 1) begin
                    m = k;
                    to_hit = !e;
                end
            end
            if (m < 0 || m + 4 >= MAXC) begin
                model_ok = 1'b0;
                exp_done_cyc = MAXC - 3;
                return;
            end
            exp_to |= to_hit;
            diff = (c > t) ? (c - t) : (t - c);
            if (s == 0 || diff <= s) nxt = t;
            else if (t > c)          nxt = c + s;
            else                     nxt = c - s;
            for (int k = m + 2; k < MAXC; k++) exp_div[k] = W'(nxt);
            c = nxt;
            if (c == t) begin
                exp_done_cyc = m + 2;
                return;
            end
            w = m + 2;
        end
    endfunction

    // Called at posedge+1 with the DUT idle; the accept happens this cycle.
    task automatic run_req(input string name, input logic [W-1:0] tgt, input logic [W-1:0] stp,
                           input logic [7:0] dw, output int nchg, output logic [W-1:0] final_div,
                           output logic final_to);
        int n, kb;
        predict(model_div, tgt, stp, dw);
        if (!model_ok) chk({name, " model_bound"}, 64'd1, 64'd0);
        n = exp_done_cyc + 2;
        request_valid   = 1'b1;
        request_divider = tgt;
        request_step    = stp;
        request_dwell   = dw;
        for (int k = 0; k < n; k++) begin
            output_clock = oc_wave[k];
            if (k == 1) begin
                // Later changes to the request inputs must have no effect.
                request_valid   = 1'b0;
                request_divider = ~tgt;
                request_step    = ~stp;
                request_dwell   = ~dw;
            end
            @(negedge clock);
            obs_div[k]  = clock_divider;
            obs_done[k] = done;
            obs_rdy[k]  = request_ready;
            obs_busy[k] = busy;
            obs_to[k]   = timed_out;
            @(posedge clock);
            #1;
        end

        kb = n - 1;
        for (int k = 0; k < n; k++) if (obs_div[k] !== exp_div[k]) begin kb = k; break; end
        chk($sformatf("%s div@%0d", name, kb), obs_div[kb], exp_div[kb]);

        kb = n - 1;
        for (int k = 0; k < n; k++) if (obs_done[k] !== (k == exp_done_cyc)) begin kb = k; break; end
        chk($sformatf("%s done@%0d", name, kb), obs_done[kb], (kb == exp_done_cyc));

        kb = n - 1;
        for (int k = 0; k < n; k++)
            if ({obs_rdy[k], obs_busy[k]} !== {(k == 0 || k == n-1), !(k == 0 || k == n-1)}) begin
                kb = k; break;
            end
        chk($sformatf("%s ready_busy@%0d", name, kb), {obs_rdy[kb], obs_busy[kb]},
            {(kb == 0 || kb == n-1), !(kb == 0 || kb == n-1)});

        chk($sformatf("%s timed_out", name), {obs_to[1], obs_to[exp_done_cyc]}, {1'b0, exp_to});

        nchg = 0;
        for (int k = 1; k < n; k++) if (obs_div[k] !== obs_div[k-1]) nchg++;
        final_div = obs_div[n-1];
        final_to  = obs_to[exp_done_cyc];
        model_div = tgt;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         vecs [9];
        int           nchg;
        logic [W-1:0] fdiv;
        logic         fto;
        int           accepts, dones, stalls;
        logic [W-1:0] div_at_done1;
        bit           reached, seen_done;
        logic [W-1:0] tgt, stp;
        logic [7:0]   dw;
        longint       tl;
        int           delta, me;

        vecs[0] = '{24'd4,        24'd0,        8'd1, 3,    2, -1, 1, 1'b0};
        vecs[1] = '{24'd1,        24'd0,        8'd0, 2,    3, -1, 1, 1'b0};
        vecs[2] = '{24'd5,        24'd2,        8'd2, 2,    2, -1, 2, 1'b0};
        vecs[3] = '{24'd0,        24'd2,        8'd1, 2,    3,  2, 3, 1'b1};
        vecs[4] = '{24'd0,        24'd5,        8'd3, 1,    2, -1, 0, 1'b0};
        vecs[5] = '{24'd7,        24'd0,        8'd1, 1024, 4, -1, 1, 1'b0};
        vecs[6] = '{24'd9,        24'd0,        8'd1, 1025, 4, -1, 1, 1'b1};
        vecs[7] = '{24'hFFFFFF,   24'h800000,   8'd1, 1,    1, -1, 2, 1'b0};
        vecs[8] = '{24'hFFFFF0,   24'd3,        8'd1, 1,    1, -1, 5, 1'b0};

        // Reset held while output_clock toggles.
        for (int i = 0; i < 6; i++) begin
            @(posedge clock); #1;
            output_clock = ~output_clock;
        end
        @(negedge clock);
        chk("rst div", clock_divider, 1);
        chk("rst ready", request_ready, 1);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst timed_out", timed_out, 0);

        // Release with output_clock high: nothing may move.
        @(posedge clock); #1;
        output_clock = 1'b1;
        reset = 1'b0;
        repeat (4) @(negedge clock);
        chk("release div", clock_divider, 1);
        chk("release busy", busy, 0);
        @(posedge clock); #1;
        model_div = 24'd1;

        for (int i = 0; i < 9; i++) begin
            build_wave(vecs[i].first, vecs[i].half, vecs[i].me);
            run_req($sformatf("vec%0d", i), vecs[i].tgt, vecs[i].stp, vecs[i].dw, nchg, fdiv, fto);
            chk($sformatf("vec%0d nsteps", i), nchg, vecs[i].nsteps);
            chk($sformatf("vec%0d final", i), fdiv, vecs[i].tgt);
            chk($sformatf("vec%0d timed_out_final", i), fto, vecs[i].to);
        end

        // Handshake: second request (target 3) held while busy.
        accepts = 0; dones = 0; stalls = 0; div_at_done1 = '0;
        request_valid = 1'b1; request_divider = 24'h10; request_step = '0; request_dwell = 8'd1;
        for (int cyc = 0; cyc < 200; cyc++) begin
            output_clock = (((cyc / 2) % 2) == 1);
            if (cyc == 1) request_divider = 24'd3;
            if (accepts == 2) request_valid = 1'b0;
            @(negedge clock);
            if (request_valid && request_ready) accepts++;
            if (request_valid && !request_ready) stalls++;
            if (done) begin
                dones++;
                if (dones == 1) div_at_done1 = clock_divider;
            end
            @(posedge clock); #1;
        end
        request_valid = 1'b0;
        chk("hs accepts", accepts, 2);
        chk("hs dones", dones, 2);
        chk("hs stall_cycles", stalls, 4);
        chk("hs first_target", div_at_done1, 24'h10);
        chk("hs final_div", clock_divider, 3);
        model_div = 24'd3;

        build_wave(1, 2, -1);
        run_req("nochange", 24'd3, 24'd5, 8'd2, nchg, fdiv, fto);
        chk("nochange nsteps", nchg, 0);

        // Randomized requests.
        for (int r = 0; r < 24; r++) begin
            me = -1;
            if (($urandom % 4) == 0) begin
                tgt = W'($urandom());
                stp = '0;
            end else begin
                delta = int'($urandom_range(0, 30));
                tl = (($urandom % 2) == 0) ? longint'(model_div) + delta : longint'(model_div) - delta;
                if (tl < 0) tl = 0;
                if (tl > 64'hFFFFFF) tl = 64'hFFFFFF;
                tgt = W'(tl);
                stp = W'($urandom_range(0, 8));
            end
            dw = 8'($urandom_range(0, 3));
            if (stp == '0 && $urandom_range(0, 9) == 0) me = int'($urandom_range(0, 1));
            build_wave(int'($urandom_range(1, 6)), int'($urandom_range(1, 4)), me);
            run_req($sformatf("rnd%0d", r), tgt, stp, dw, nchg, fdiv, fto);
        end

        // Asynchronous reset from a non-reset divisor.
        build_wave(1, 2, -1);
        run_req("pre_rst", 24'h123, 24'd0, 8'd1, nchg, fdiv, fto);
        reset = 1'b1;
        #2;
        chk("async rst div", clock_divider, 1);
        chk("async rst ready", request_ready, 1);
        @(posedge clock); #1;
        reset = 1'b0;
        model_div = 24'd1;

        // Reset mid-ramp 1 -> 5 after the divisor has reached 3.
        reached = 1'b0; seen_done = 1'b0;
        request_valid = 1'b1; request_divider = 24'd5; request_step = 24'd2; request_dwell = 8'd1;
        for (int cyc = 0; cyc < 200; cyc++) begin
            output_clock = (((cyc / 2) % 2) == 1);
            if (cyc == 1) request_valid = 1'b0;
            @(negedge clock);
            if (clock_divider == 24'd3) begin
                reached = 1'b1;
                break;
            end
            @(posedge clock); #1;
        end
        chk("midramp reached3", reached, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("midramp rst div", clock_divider, 1);
        chk("midramp rst busy", busy, 0);
        seen_done = done;
        repeat (2) begin @(negedge clock); seen_done |= done; end
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (3) begin @(negedge clock); seen_done |= done; end
        chk("midramp no_done", seen_done, 0);
        chk("midramp ready", request_ready, 1);
        chk("midramp div", clock_divider, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
